// File: rtl/two_port_ram_be.sv
// True dual-port synchronous RAM with byte-lane writes, selectable read-during-write,
// optional output register, collision flag and a post-reset clear sequencer.
module two_port_ram_be #(
    parameter int ADDR_W   = 8,
    parameter int WORD_W   = 64,
    parameter int BYTE_W   = 8,
    parameter int RD_MODE  = 0,
    parameter int OUT_REG  = 0,
    parameter int CLEAR_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    output logic                       collision,
    input  logic                       en_a,
    input  logic                       en_b,
    input  logic                       wren_a,
    input  logic                       wren_b,
    input  logic [WORD_W/BYTE_W-1:0]   be_a,
    input  logic [WORD_W/BYTE_W-1:0]   be_b,
    input  logic [ADDR_W-1:0]          address_a,
    input  logic [ADDR_W-1:0]          address_b,
    input  logic [WORD_W-1:0]          data_a,
    input  logic [WORD_W-1:0]          data_b,
    output logic [WORD_W-1:0]          q_a,
    output logic [WORD_W-1:0]          q_b,
    output logic                       valid_a,
    output logic                       valid_b,
    output logic [1:0]                 state_dbg
);
    localparam int NB    = WORD_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_RUN = 2'd2} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic                run, wr_a, wr_b, same_addr;
    logic [WORD_W-1:0]   old_a, old_b, new_a, new_b, wdata_a, ret_a, ret_b;
    logic                s_valid_a, s_valid_b;
    logic [WORD_W-1:0]   s_q_a, s_q_b;

    function automatic logic [WORD_W-1:0] merge(input logic [WORD_W-1:0] old_w,
                                                input logic [WORD_W-1:0] new_w,
                                                input logic [NB-1:0]     be);
        logic [WORD_W-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++)
            if (be[i]) r[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = (CLEAR_EN != 0) ? S_CLEAR : S_RUN;
            S_CLEAR: if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign run       = (state == S_RUN);
    assign ready     = run;
    assign state_dbg = state;

    assign wr_a      = run && en_a && wren_a;
    assign wr_b      = run && en_b && wren_b;
    assign same_addr = (address_a == address_b);
    assign old_a     = mem[address_a];
    assign old_b     = mem[address_b];
    assign new_a     = merge(old_a, data_a, be_a);
    assign new_b     = merge(old_b, data_b, be_b);
    // On a same-address double write, A's lanes are laid over B's merged word so A wins.
    assign wdata_a   = (wr_b && same_addr) ? merge(new_b, data_a, be_a) : new_a;
    assign ret_a     = (wren_a && RD_MODE == 0) ? new_a : old_a;
    assign ret_b     = (wren_b && RD_MODE == 0) ? new_b : old_b;

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (wr_b && !(wr_a && same_addr)) mem[address_b] <= new_b;
            if (wr_a) mem[address_a] <= wdata_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid_a <= 1'b0;
            s_valid_b <= 1'b0;
            s_q_a     <= '0;
            s_q_b     <= '0;
            collision <= 1'b0;
        end else begin
            s_valid_a <= run && en_a;
            s_valid_b <= run && en_b;
            if (run && en_a) s_q_a <= ret_a;
            if (run && en_b) s_q_b <= ret_b;
            collision <= wr_a && wr_b && same_addr && (|(be_a & be_b));
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_a <= 1'b0;
                    valid_b <= 1'b0;
                    q_a     <= '0;
                    q_b     <= '0;
                end else begin
                    valid_a <= s_valid_a;
                    valid_b <= s_valid_b;
                    if (s_valid_a) q_a <= s_q_a;
                    if (s_valid_b) q_b <= s_q_b;
                end
            end
        end else begin : g_no_out_reg
            assign valid_a = s_valid_a;
            assign valid_b = s_valid_b;
            assign q_a     = s_q_a;
            assign q_b     = s_q_b;
        end
    endgenerate
endmodule

// File: tb/tb_two_port_ram_be.sv
// Directed bench: u0 is write-first with 1-cycle latency, u1 is read-first with 2-cycle latency.
module tb_two_port_ram_be;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_a = 0, en_b = 0, wren_a = 0, wren_b = 0;
    logic [7:0]  be_a = 0, be_b = 0;
    logic [3:0]  address_a = 0, address_b = 0;
    logic [63:0] data_a = 0, data_b = 0;

    logic        ready0, collision0, valid_a0, valid_b0;
    logic        ready1, collision1, valid_a1, valid_b1;
    logic [63:0] q_a0, q_b0, q_a1, q_b1;
    logic [1:0]  state_dbg0, state_dbg1;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] V = 64'h1122334455667788;

    always #5 clk = ~clk;

    two_port_ram_be #(.ADDR_W(4), .WORD_W(64), .BYTE_W(8), .RD_MODE(0), .OUT_REG(0), .CLEAR_EN(1)) u0 (
        .clk(clk), .rst(rst), .ready(ready0), .collision(collision0),
        .en_a(en_a), .en_b(en_b), .wren_a(wren_a), .wren_b(wren_b),
        .be_a(be_a), .be_b(be_b), .address_a(address_a), .address_b(address_b),
        .data_a(data_a), .data_b(data_b), .q_a(q_a0), .q_b(q_b0),
        .valid_a(valid_a0), .valid_b(valid_b0), .state_dbg(state_dbg0));

    two_port_ram_be #(.ADDR_W(4), .WORD_W(64), .BYTE_W(8), .RD_MODE(1), .OUT_REG(1), .CLEAR_EN(1)) u1 (
        .clk(clk), .rst(rst), .ready(ready1), .collision(collision1),
        .en_a(en_a), .en_b(en_b), .wren_a(wren_a), .wren_b(wren_b),
        .be_a(be_a), .be_b(be_b), .address_a(address_a), .address_b(address_b),
        .data_a(data_a), .data_b(data_b), .q_a(q_a1), .q_b(q_b1),
        .valid_a(valid_a1), .valid_b(valid_b1), .state_dbg(state_dbg1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic en, input logic wr, input logic [7:0] be,
                         input logic [3:0] addr, input logic [63:0] d);
        en_a = en; wren_a = wr; be_a = be; address_a = addr; data_a = d;
    endtask

    task automatic set_b(input logic en, input logic wr, input logic [7:0] be,
                         input logic [3:0] addr, input logic [63:0] d);
        en_b = en; wren_b = wr; be_b = be; address_b = addr; data_b = d;
    endtask

    task automatic idle();
        set_a(0, 0, 8'h00, 4'd0, 64'h0);
        set_b(0, 0, 8'h00, 4'd0, 64'h0);
    endtask

    // Counts edges from reset release until ready; 1 idle edge plus 16 clear cycles.
    task automatic wait_ready(input string tag);
        int   n;
        logic seen_valid;
        n = 0;
        seen_valid = 1'b0;
        set_a(1, 0, 8'h00, 4'd0, 64'h0);
        while (n < 40 && !ready0) begin
            step();
            n++;
            seen_valid = seen_valid | valid_a0 | valid_a1;
        end
        idle();
        chk({tag, "_ready_latency"}, 64'(n), 64'd17);
        chk({tag, "_ready1"}, 64'(ready1), 64'd1);
        chk({tag, "_no_valid_in_clear"}, 64'(seen_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 rst = 1'b1;
        set_a(1, 0, 8'h00, 4'd1, 64'h0);
        step(); step();
        chk("rst_ready0", 64'(ready0), 64'd0);
        chk("rst_ready1", 64'(ready1), 64'd0);
        chk("rst_valid_a0", 64'(valid_a0), 64'd0);
        chk("rst_valid_a1", 64'(valid_a1), 64'd0);
        chk("rst_q_a0", q_a0, 64'h0);
        chk("rst_q_b1", q_b1, 64'h0);
        chk("rst_collision0", 64'(collision0), 64'd0);
        chk("rst_state0", 64'(state_dbg0), 64'd0);
        rst = 1'b0;

        // Clear sequence, then every word reads back zero
        wait_ready("clear1");
        chk("run_state0", 64'(state_dbg0), 64'd2);
        for (int i = 0; i < 16; i++) begin
            set_a(1, 0, 8'h00, 4'(i), 64'h0);
            step();
            idle();
            chk("clr_rd_q_a0", q_a0, 64'h0);
            chk("clr_rd_valid_a0", 64'(valid_a0), 64'd1);
            step();
            chk("clr_rd_q_a1", q_a1, 64'h0);
            chk("clr_rd_valid_a1", 64'(valid_a1), 64'd1);
        end
        chk("idle_valid_a0", 64'(valid_a0), 64'd0);

        // Full write on A, read on B next cycle
        set_a(1, 1, 8'hFF, 4'd3, V);
        step();
        chk("wr3_q_a0_new", q_a0, V);
        chk("wr3_valid_a0", 64'(valid_a0), 64'd1);
        idle();
        set_b(1, 0, 8'h00, 4'd3, 64'h0);
        step();
        idle();
        chk("rd3_q_b0", q_b0, V);
        chk("rd3_valid_b0", 64'(valid_b0), 64'd1);
        chk("rd3_valid_a0_off", 64'(valid_a0), 64'd0);
        chk("wr3_q_a1_old", q_a1, 64'h0);
        chk("wr3_valid_a1", 64'(valid_a1), 64'd1);
        step();
        chk("rd3_q_b1", q_b1, V);
        chk("rd3_valid_b1", 64'(valid_b1), 64'd1);
        chk("rd3_valid_a1_off", 64'(valid_a1), 64'd0);

        // Partial byte-lane write
        set_a(1, 1, 8'h0F, 4'd3, 64'hAAAAAAAAAAAAAAAA);
        step();
        chk("pw_q_a0", q_a0, 64'h11223344AAAAAAAA);
        idle();
        set_b(1, 0, 8'h00, 4'd3, 64'h0);
        step();
        idle();
        chk("pw_rd_q_b0", q_b0, 64'h11223344AAAAAAAA);
        chk("pw_q_a1_old", q_a1, V);
        step();
        chk("pw_rd_q_b1", q_b1, 64'h11223344AAAAAAAA);

        // Same-port read-during-write mode
        set_a(1, 1, 8'hFF, 4'd5, 64'h2);
        step();
        idle();
        step(); step();
        set_a(1, 1, 8'hFF, 4'd5, 64'h1);
        step();
        idle();
        chk("rdw_q_a0_new", q_a0, 64'h1);
        step();
        chk("rdw_q_a1_old", q_a1, 64'h2);

        // Both ports write the same address with overlapping lanes
        set_a(1, 1, 8'hFF, 4'd7, 64'hA);
        set_b(1, 1, 8'hFF, 4'd7, 64'hB);
        step();
        idle();
        chk("coll_pulse0", 64'(collision0), 64'd1);
        chk("coll_pulse1", 64'(collision1), 64'd1);
        step();
        chk("coll_end0", 64'(collision0), 64'd0);
        set_a(1, 0, 8'h00, 4'd7, 64'h0);
        step();
        idle();
        chk("coll_a_wins0", q_a0, 64'hA);
        step();
        chk("coll_a_wins1", q_a1, 64'hA);

        // Disjoint lanes on the same address: merge, no collision
        set_a(1, 1, 8'h0F, 4'd8, 64'h1111111111111111);
        set_b(1, 1, 8'hF0, 4'd8, 64'h2222222222222222);
        step();
        idle();
        chk("disjoint_no_coll", 64'(collision0), 64'd0);
        set_a(1, 0, 8'h00, 4'd8, 64'h0);
        step();
        idle();
        chk("disjoint_merge", q_a0, 64'h2222222211111111);
        step();

        // Partially overlapping lanes: A takes the shared lane
        set_a(1, 1, 8'h01, 4'd9, 64'hAAAAAAAAAAAAAAAA);
        set_b(1, 1, 8'h03, 4'd9, 64'hBBBBBBBBBBBBBBBB);
        step();
        idle();
        chk("overlap_coll", 64'(collision0), 64'd1);
        set_a(1, 0, 8'h00, 4'd9, 64'h0);
        step();
        idle();
        chk("overlap_merge", q_a0, 64'h000000000000BBAA);
        step();

        // A writes while B reads the same address: B sees the old word
        set_a(1, 1, 8'hFF, 4'd7, 64'hC);
        set_b(1, 0, 8'h00, 4'd7, 64'h0);
        step();
        idle();
        chk("xport_q_b0_old", q_b0, 64'hA);
        chk("xport_q_a0_new", q_a0, 64'hC);
        step();
        chk("xport_q_b1_old", q_b1, 64'hA);
        chk("xport_q_a1_old", q_a1, 64'hA);

        // Write with no lanes enabled behaves as a read
        set_a(1, 1, 8'h00, 4'd7, 64'hFFFFFFFFFFFFFFFF);
        step();
        chk("be0_q_a0", q_a0, 64'hC);
        chk("be0_valid_a0", 64'(valid_a0), 64'd1);
        set_a(1, 0, 8'h00, 4'd7, 64'h0);
        step();
        idle();
        chk("be0_unchanged", q_a0, 64'hC);
        step(); step();

        // Reset in the middle of the clear restarts it from address 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("midclr_state0", 64'(state_dbg0), 64'd1);
        rst = 1'b1;
        #1;
        chk("midclr_ready0", 64'(ready0), 64'd0);
        chk("midclr_state_idle", 64'(state_dbg0), 64'd0);
        step(); step();
        rst = 1'b0;
        wait_ready("clear2");
        set_a(1, 0, 8'h00, 4'd8, 64'h0);
        set_b(1, 0, 8'h00, 4'd9, 64'h0);
        step();
        idle();
        chk("reclr_q_a0", q_a0, 64'h0);
        chk("reclr_q_b0", q_b0, 64'h0);
        step();
        chk("reclr_q_a1", q_a1, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Async reset check: outputs drop without waiting for a clock edge.
    initial begin
        @(posedge rst);
        @(posedge rst);
        @(posedge rst);
        #0.5;
        chk("async_q_a0", q_a0, 64'h0);
        chk("async_q_b0", q_b0, 64'h0);
        chk("async_valid_a0", 64'(valid_a0), 64'd0);
    end
endmodule
